// File: rtl/fifo_pkg.sv
// Shared defaults and types for the synchronous FIFO.
// The modules take their parameter defaults from here; benches use fifo_data_t directly.
package fifo_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] fifo_data_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH simple dual-port register array.
// Synchronous write port; registered read port that holds its value unless rd_en is high.
module sync_fifo_mem #(
  parameter int  DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int  DEPTH      = fifo_pkg::DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // NOTE: the storage array has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // NOTE: the default hold value comes first so every path assigns rd_data_d and no latch is inferred.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // rst_n is active-high on this block despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count bookkeeping, status flags and handshake pulses.
// Storage and the registered read port live in sync_fifo_mem.
module sync_fifo #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  write_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_d, count_q;
  logic                  write_ack_d, write_ack_q;
  logic                  overflow_d, overflow_q;
  logic                  underflow_d, underflow_q;
  logic                  wr_accept, rd_accept;

  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q == AF_CNT);
  assign almost_empty = (count_q == (ADDR_WIDTH+1)'(1));

  // Gating on the pre-edge flags gives the empty/full simultaneous cases for free:
  // an empty FIFO only writes, a full FIFO only reads.
  assign wr_accept = write_enable && !full;
  assign rd_accept = read_enable  && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    write_ack_d = wr_accept;
    overflow_d  = write_enable && !wr_accept;
    underflow_d = read_enable  && !rd_accept;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      write_ack_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      write_ack_q <= write_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign write_ack = write_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed plan steps plus random traffic, all checked
// against a queue-based reference model after every clock.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  fifo_data_t data_in;
  logic       write_enable, read_enable;
  fifo_data_t data_out;
  logic       full, empty, almost_full, almost_empty;
  logic       write_ack, overflow, underflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  fifo_data_t model_q[$];
  fifo_data_t exp_dout;
  logic       exp_ack, exp_ovf, exp_unf;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .write_ack    (write_ack),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".data_out"},     32'(data_out),     32'(exp_dout));
    check({tag, ".full"},         32'(full),         32'(n == DEPTH));
    check({tag, ".empty"},        32'(empty),        32'(n == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(n == DEPTH - 1));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n == 1));
    check({tag, ".write_ack"},    32'(write_ack),    32'(exp_ack));
    check({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
    check({tag, ".underflow"},    32'(underflow),    32'(exp_unf));
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout = '0;
    exp_ack  = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model, check just after posedge.
  task automatic cycle(input logic we, input logic re, input fifo_data_t din, input string tag);
    bit wr_ok, rd_ok;
    @(negedge clk);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    wr_ok = we && (model_q.size() < DEPTH);
    rd_ok = re && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(din);
    exp_ack = wr_ok;
    exp_ovf = we && !wr_ok;
    exp_unf = re && !rd_ok;
    check_all(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
    rst_n        = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
    model_reset();

    // Power-on reset state.
    #12;
    check_all("reset_init");
    release_reset();
    cycle(1'b0, 1'b0, '0, "idle");

    // Basic write then read.
    cycle(1'b1, 1'b0, 16'hAAAA, "wr_aaaa");
    cycle(1'b0, 1'b1, '0,       "rd_aaaa");
    check("rd_aaaa_value", 32'(data_out), 32'h0000_AAAA);

    // Fill to full, then one rejected write.
    for (int i = 1; i <= DEPTH + 1; i++) cycle(1'b1, 1'b0, fifo_data_t'(i), "fill");
    check("fill_full", 32'(full), 32'd1);

    // Drain, then one rejected read.
    for (int i = 0; i <= DEPTH; i++) cycle(1'b0, 1'b1, '0, "drain");
    check("drain_last", 32'(data_out), 32'h0000_0008);

    // Simultaneous read/write at occupancy 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, fifo_data_t'(16'h0030 + i), "pre3");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, fifo_data_t'(16'h0040 + i), "both3");
    check("both3_count", 32'(model_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, "post3");

    // Simultaneous on empty: write lands, read underflows.
    cycle(1'b1, 1'b1, 16'h1234, "both_empty");
    cycle(1'b0, 1'b1, '0,       "rd_1234");
    check("rd_1234_value", 32'(data_out), 32'h0000_1234);

    // Simultaneous on full: read happens, write overflows.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, fifo_data_t'(16'h0050 + i), "fill2");
    cycle(1'b1, 1'b1, 16'hDEAD, "both_full");
    check("both_full_af", 32'(almost_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0, "drain2");

    // Wrap-around: interleaved traffic keeping occupancy between 2 and 6.
    cycle(1'b1, 1'b0, 16'h00F0, "wrap_pre");
    cycle(1'b1, 1'b0, 16'h00F1, "wrap_pre");
    for (int i = 0; i < 20; i++) begin
      int  n;
      int  pick;
      logic we, re;
      n    = model_q.size();
      pick = int'($urandom_range(0, 2));
      if (n <= 2)      begin we = 1'b1; re = 1'b0; end
      else if (n >= 6) begin we = 1'b0; re = 1'b1; end
      else             begin we = (pick != 1); re = (pick != 0); end
      cycle(we, re, fifo_data_t'(32'h0100 + i), "wrap");
    end

    // Asynchronous reset mid-cycle with entries stored.
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    release_reset();
    cycle(1'b1, 1'b0, 16'hAAAA, "post_rst_wr");
    cycle(1'b0, 1'b1, '0,       "post_rst_rd");
    check("post_rst_value", 32'(data_out), 32'h0000_AAAA);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), fifo_data_t'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock synchronous FIFO with registered read data.
It provides status flags (full/empty/almost_full/almost_empty) and per-cycle handshake/error pulses (write_ack/overflow/underflow).
It sits between a producer and a consumer in the same clock domain and serves as the standard buffering primitive for the datapath.

Parameters:
DATA_WIDTH, 16, width of data_in/data_out in bits
DEPTH, 8, number of entries; power of two, >= 4
ADDR_WIDTH, $clog2(DEPTH), derived pointer width (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous, active-high (1 = reset asserted)
data_in  input  DATA_WIDTH  write data
write_enable  input  1  write request
read_enable  input  1  read request
data_out  output  DATA_WIDTH  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count == DEPTH-1
almost_empty  output  1  count == 1
write_ack  output  1  registered; 1 for the cycle after an accepted write
overflow  output  1  registered; 1 for the cycle after a write rejected because full
underflow  output  1  registered; 1 for the cycle after a read rejected because empty

Behaviour:
- Reset (rst_n=1, asynchronous, takes effect immediately):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out, write_ack, overflow and underflow go to 0.
  - Hence empty=1 and full=almost_full=almost_empty=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored entries; the first write after release lands at address 0.
- Write accepted iff write_enable && !full:
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
  - write_ack=1 next cycle.
- Write with full asserted: no storage change, pointers hold, overflow=1 next cycle, write_ack=0.
- Read accepted iff read_enable && !empty:
  - data_out <= mem[rd_ptr] at that edge, so the value is visible 1 cycle after the request.
  - rd_ptr increments modulo DEPTH.
- Read with empty asserted: data_out holds its previous value, underflow=1 next cycle.
- data_out holds its value on every cycle without an accepted read.
- Simultaneous write_enable && read_enable:
  - Neither full nor empty: both occur, count unchanged.
  - Empty: only the write occurs (count becomes 1) and underflow=1.
  - Full: only the read occurs (count becomes DEPTH-1) and overflow=1.
  - No same-cycle write-through: a read never returns data written in the same edge.
- write_ack, overflow and underflow are recomputed every cycle (pulses, not sticky).
- Flags full, empty, almost_full and almost_empty are combinational decodes of count (count width ADDR_WIDTH+1). They reflect the state after the last edge.
- Pointer wrap: pointers roll DEPTH-1 -> 0 seamlessly; FIFO order is preserved across wrap.
- Only one count update occurs per cycle:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - 0 on both accepted or neither.

Decomposition:
- Package fifo_pkg: DATA_WIDTH and DEPTH defaults, ADDR_WIDTH derivation, and typedef fifo_data_t (logic [DATA_WIDTH-1:0]).
- One sub-module is natural: sync_fifo_mem, a DEPTH x DATA_WIDTH simple dual-port register array with a synchronous write port and a registered read port with read enable.
- Pointer, count, flag and handshake logic stay in sync_fifo.

Test Plan:
- Reset check: assert rst_n=1 asynchronously mid-cycle -> outputs zero immediately, empty=1, full=0; after release, write 0xAAAA then read -> data_out=0xAAAA.
- Fill to full: write 0x0001..0x0008 on consecutive cycles.
  - write_ack=1 each following cycle.
  - almost_full=1 after the 7th write, full=1 after the 8th.
  - A 9th write gives overflow=1, write_ack=0, and the contents are unchanged.
- Drain: read 8 times -> data_out=0x0001..0x0008 in order, each one cycle after its request; almost_empty=1 when 1 entry remains; empty=1 at the end; a 9th read gives underflow=1 and data_out stays 0x0008.
- Simultaneous read/write with 3 entries: assert both for 4 cycles -> count stays 3, output order is preserved, no flags.
- Edge cases of simultaneous read/write:
  - Empty FIFO: write 0x1234 is accepted and underflow=1; the next read returns 0x1234.
  - Full FIFO: only the read happens, overflow=1, count=7.
- Wrap-around: 20 cycles of interleaved writes (0x0100+i) and reads with occupancy 2-6 -> every read matches the scoreboard, pointers wrap past 7, and no spurious overflow/underflow.
